alu_seq: RTL

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It generalises the datapath to WIDTH bits and registers all results and flags. It adds a valid/ready interface on input and output, a zero flag, an illegal-opcode flag, and an optional multi-cycle shift-add multiply. It sits between an operand/opcode producer and a result consumer, with one operation in flight at a time.

---
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked, registered WIDTH-bit ALU with one op in flight.
//
// A request is captured on in_valid && in_ready, evaluated from the captured
// operands on the following cycle, and the registered result and flags are
// presented with out_valid until the consumer takes them (out_valid &&
// out_ready). Results and flags hold stable under backpressure.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : opcode 11 is an iterative shift-add multiply (WIDTH cycles).
//   undefined : no multiplier logic; opcode 11 is reported as illegal.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand_a / operand_b / opcode are valid
//   in_ready   out  request can be accepted (FSM idle)
//   operand_a  in   [WIDTH-1:0] first operand
//   operand_b  in   [WIDTH-1:0] second operand
//   opcode     in   [3:0] operation select
//   out_valid  out  result and flags are valid
//   out_ready  in   consumer takes the result
//   result     out  [WIDTH-1:0] registered result
//   carry_out  out  carry / borrow / multiply-overflow
//   overflow   out  signed overflow
//   zero       out  result == 0
//   illegal    out  unsupported opcode
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             illegal
);

   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NEG  = 4'd2,
      OP_INC  = 4'd3,
      OP_DEC  = 4'd4,
      OP_ROL  = 4'd5,
      OP_OR   = 4'd6,
      OP_AND  = 4'd7,
      OP_XOR  = 4'd8,
      OP_MAX  = 4'd9,
      OP_PASS = 4'd10,
      OP_MUL  = 4'd11
   } op_e;

   // EXEC is the cycle in which the captured operands are evaluated.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
`ifdef ALU_SEQ_MUL_EN
      S_MUL  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_e;

   state_e           state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       op_q;

   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] res_c;
   logic             c_c, v_c, ill_c;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   // Single-cycle datapath, evaluated from the captured operands.
   // NOTE: every output of this block gets a default first so no path
   // through the case statement leaves a latch behind.
   always_comb begin
      sum   = {1'b0, a_q} + {1'b0, b_q};
      diff  = {1'b0, a_q} - {1'b0, b_q};
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
      ill_c = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_c = sum[WIDTH-1:0];
            c_c   = sum[WIDTH];
            v_c   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
         end
         OP_SUB: begin
            res_c = diff[WIDTH-1:0];
            c_c   = diff[WIDTH];   // borrow out: a < b unsigned
            v_c   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
         end
         OP_NEG:  res_c = ~a_q + ONE;
         OP_INC:  res_c = a_q + ONE;
         OP_DEC:  res_c = a_q - ONE;
         OP_ROL:  res_c = {a_q[WIDTH-2:0], a_q[MSB]};
         OP_OR:   res_c = a_q | b_q;
         OP_AND:  res_c = a_q & b_q;
         OP_XOR:  res_c = a_q ^ b_q;
         OP_MAX:  res_c = (a_q > b_q) ? a_q : b_q;
         OP_PASS: res_c = a_q;
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:  ;   // product comes from the shift-add path below
`endif
         default: ill_c = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   acc, acc_next, pp;

   // One multiplier bit per cycle: add a shifted copy of a when b[cnt] is set.
   always_comb begin
      pp = '0;
      if (b_q[cnt]) pp = {{WIDTH{1'b0}}, a_q} << cnt;
      acc_next = acc + pp;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   // NOTE: everything, including the operand registers, is cleared on reset so
   // nothing stale can ever reach the outputs after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         cnt       <= '0;
         acc       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= operand_a;
                  b_q   <= operand_b;
                  op_q  <= opcode;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
`ifdef ALU_SEQ_MUL_EN
               if (op_q == OP_MUL) begin
                  cnt   <= '0;
                  acc   <= '0;
                  state <= S_MUL;
               end else
`endif
               begin
                  result    <= res_c;
                  carry_out <= c_c;
                  overflow  <= v_c;
                  zero      <= (res_c == '0);
                  illegal   <= ill_c;
                  state     <= S_DONE;
               end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  result    <= acc_next[WIDTH-1:0];
                  carry_out <= |acc_next[2*WIDTH-1:WIDTH];
                  overflow  <= 1'b0;
                  zero      <= (acc_next[WIDTH-1:0] == '0);
                  illegal   <= 1'b0;
                  state     <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
